// File: rtl/md_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package md_pkg;

    // Operation select encoding on the op input.
    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate. With neg tied to an operand's sign bit
// it yields the magnitude; with neg set to the result sign it restores the sign.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    // Negate when requested, otherwise pass through unchanged.
    always_comb res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_div_seq.sv
// Sequential multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, with start/busy/done handshake, abort and div-by-zero flag.
module mult_div_seq
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    // acc: upper product half / partial remainder; q: lower product half / quotient
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    // m: multiplicand magnitude (mult) or divisor magnitude (div)
    logic [WIDTH-1:0] m;
    logic             op_r;
    logic             neg_q;   // negate product / quotient at FIX
    logic             neg_r;   // negate remainder at FIX

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    logic sgn_a, sgn_b;
    assign sgn_a = is_signed & a[WIDTH-1];
    assign sgn_b = is_signed & b[WIDTH-1];

    md_sign_fix #(.W(WIDTH))   u_mag_a   (.val(a),        .neg(sgn_a), .res(a_mag));
    md_sign_fix #(.W(WIDTH))   u_mag_b   (.val(b),        .neg(sgn_b), .res(b_mag));
    md_sign_fix #(.W(2*WIDTH)) u_fix_prd (.val({acc, q}), .neg(neg_q), .res(prod_fix));
    md_sign_fix #(.W(WIDTH))   u_fix_quo (.val(q),        .neg(neg_q), .res(quo_fix));
    md_sign_fix #(.W(WIDTH))   u_fix_rem (.val(acc),      .neg(neg_r), .res(rem_fix));

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum   = q[0] ? ({1'b0, acc} + {1'b0, m}) : {1'b0, acc};
        div_shift = {acc, q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, m});
        // The true difference is below m whenever it is used, so WIDTH bits suffice.
        div_diff  = div_shift[WIDTH-1:0] - m;
    end

    // Controller, iteration datapath and registered result/handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            op_r     <= MD_MULT;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        op_r     <= op;
                        cnt      <= CNT_W'(WIDTH);
                        acc      <= '0;
                        busy     <= 1'b1;
                        neg_q    <= sgn_a ^ sgn_b;
                        div_zero <= (op == MD_DIV) && (b == '0);
                        if (op == MD_DIV) begin
                            q     <= a_mag;
                            m     <= b_mag;
                            neg_r <= sgn_a;
                            state <= (b == '0) ? FIX : RUN;
                        end else begin
                            q     <= b_mag;
                            m     <= a_mag;
                            neg_r <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (op_r == MD_DIV) begin
                            acc <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], div_ge};
                        end else begin
                            acc <= mul_sum[WIDTH:1];
                            q   <= {mul_sum[0], q[WIDTH-1:1]};
                        end
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!abort) begin
                        done <= 1'b1;
                        if (!div_zero) begin
                            if (op_r == MD_MULT) begin
                                {hi, lo} <= prod_fix;
                            end else begin
                                lo <= quo_fix;
                                hi <= rem_fix;
                            end
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq at WIDTH = 32.
module tb_mult_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic         is_signed;
    logic         abort;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mult_div_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
        .abort(abort), .a(a), .b(b), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model using native wide arithmetic.
    function automatic exp_t model(input logic o, input logic s,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx, sy, sq, sr;
        logic [63:0] p, vq, vr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dz  = 1'b0;
        e.lat = W + 1;
        if (o == 1'b0) begin
            if (s) p = 64'(sx * sy);
            else   p = {32'b0, x} * {32'b0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == '0) begin
            e.hi  = m_hi;
            e.lo  = m_lo;
            e.dz  = 1'b1;
            e.lat = 1;
        end else if (s) begin
            sq = sx / sy;
            sr = sx % sy;
            vq = 64'(sq);
            vr = 64'(sr);
            e.lo = vq[31:0];
            e.hi = vr[31:0];
        end else begin
            e.lo = x / y;
            e.hi = x % y;
        end
        return e;
    endfunction

    // Drive one start pulse; returns just after the accepting edge.
    task automatic issue(input logic o, input logic s, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; is_signed = s; a = x; b = y;
        if (push) begin
            e = model(o, s, x, y);
            sb_q.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then pop the scoreboard and compare.
    task automatic wait_done(input string name, input int n0, output int bcnt);
        int   n;
        bit   got;
        exp_t e;
        n = n0;
        got = 0;
        bcnt = busy ? 1 : 0;
        while (!got && n < W + 10) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bcnt++;
            if (done) got = 1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s timeout: no done after %0d cycles, required done", name, n);
        end else if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s: done with empty scoreboard, required no done", name);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (n !== e.lat) begin
                failures++;
                $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
            end
            checks++;
            if (hi !== e.hi) begin
                failures++;
                $display("FAIL %s hi: got %h required %h", name, hi, e.hi);
            end
            checks++;
            if (lo !== e.lo) begin
                failures++;
                $display("FAIL %s lo: got %h required %h", name, lo, e.lo);
            end
            checks++;
            if (div_zero !== e.dz) begin
                failures++;
                $display("FAIL %s div_zero: got %b required %b", name, div_zero, e.dz);
            end
        end
    endtask

    task automatic do_op(input string name, input logic o, input logic s,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        int bc;
        issue(o, s, x, y, 1'b1);
        wait_done(name, 0, bc);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 1'b0; is_signed = 1'b0; abort = 1'b0;
        a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset done: got %b required 0", done); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset div_zero: got %b required 0", div_zero); end
        checks++; if (hi !== '0)         begin failures++; $display("FAIL reset hi: got %h required 0", hi); end
        checks++; if (lo !== '0)         begin failures++; $display("FAIL reset lo: got %h required 0", lo); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult_max();
        int bc;
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("mult_max", 0, bc);
        checks++;
        if (bc !== W + 1) begin
            failures++;
            $display("FAIL mult_max busy_cycles: got %0d required %0d", bc, W + 1);
        end
    endtask

    task automatic test_mult_signed();
        do_op("mult_s_m3x7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
        do_op("mult_u_m3x7", 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7);
        do_op("mult_s_negneg", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_div();
        do_op("div_s_m7d2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_op("div_u_100d7", 1'b1, 1'b0, 32'd100, 32'd7);
        do_op("div_s_7dm2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_op("div_s_min_m1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_div_zero();
        do_op("preload_6x7", 1'b0, 1'b0, 32'd6, 32'd7);
        do_op("div_5d0", 1'b1, 1'b0, 32'd5, 32'd0);
        // Back-to-back: the next start lands in the done cycle and clears the flag.
        issue(1'b0, 1'b0, 32'd3, 32'd3, 1'b1);
        checks++;
        if (div_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_zero_clear: got %b required 0", div_zero);
        end
        begin
            int bc;
            wait_done("after_div0", 0, bc);
        end
    endtask

    task automatic test_back_to_back();
        do_op("b2b_1", 1'b0, 1'b0, 32'd12345, 32'd678);
        do_op("b2b_2", 1'b1, 1'b0, 32'd12345, 32'd678);
        do_op("b2b_3", 1'b1, 1'b1, 32'hFFFF_CFC7, 32'd678);
    endtask

    task automatic test_start_ignored();
        int bc;
        issue(1'b0, 1'b0, 32'd6, 32'd7, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start_ignored", 5, bc);
    endtask

    task automatic test_abort();
        logic [W-1:0] h0, l0;
        h0 = hi;
        l0 = lo;
        // abort together with start in IDLE blocks the start
        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle busy: got %b required 0", busy); end
        issue(1'b0, 1'b0, 32'd9, 32'd9, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort busy: got %b required 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL abort done: got %b required 0", done); end
        checks++;
        if ({hi, lo} !== {h0, l0}) begin
            failures++;
            $display("FAIL abort hilo: got %h_%h required %h_%h", hi, lo, h0, l0);
        end
        do_op("after_abort", 1'b0, 1'b1, 32'd5, 32'hFFFF_FFFB);
    endtask

    task automatic test_async_reset();
        issue(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset busy: got %b required 0", busy); end
        checks++; if (hi !== '0)     begin failures++; $display("FAIL async_reset hi: got %h required 0", hi); end
        checks++; if (lo !== '0)     begin failures++; $display("FAIL async_reset lo: got %h required 0", lo); end
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        do_op("after_reset", 1'b1, 1'b0, 32'd1000, 32'd3);
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic o, s;
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            y = (i == 3) ? 32'd0 : $urandom;
            o = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            do_op($sformatf("rand_%0d", i), o, s, x, y);
        end
    endtask

    initial begin
        test_reset();
        test_mult_max();
        test_mult_signed();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_start_ignored();
        test_abort();
        test_async_reset();
        test_random();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
